pkt_rx_parser: RTL and testbench

PKT_RX_PARSER -- requirements
Module: pkt_rx_parser

---
 rtl/pkt_rx_parser_pkg.sv | 45 ++++
 rtl/pkt_rx_parser_if.sv | 12 +
 rtl/pkt_rx_parser.sv | 241 ++++++++++++++++++++++++
 tb/tb_pkt_rx_parser.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_rx_parser_pkg.sv
// Shared packet definitions for the radio receive path (parser and reward block).
// PKT_CHECKSUM_EN adds the CHK state used by the optional trailing XOR word.
package pkt_rx_parser_pkg;

  typedef enum logic [2:0] {
    PT_HEARTBEAT   = 3'b000,
    PT_CH_ELECT    = 3'b001,
    PT_CH_TIMESLOT = 3'b010,
    PT_DATA_3      = 3'b011,
    PT_DATA_4      = 3'b100,
    PT_DATA_5      = 3'b101,
    PT_DATA_6      = 3'b110,
    PT_INVALID     = 3'b111
  } pkt_type_e;

  localparam logic [3:0] LEN_HEARTBEAT   = 4'd6;
  localparam logic [3:0] LEN_CH_ELECT    = 4'd8;
  localparam logic [3:0] LEN_CH_TIMESLOT = 4'd3;
  localparam logic [3:0] LEN_GENERIC     = 4'd8;

  localparam logic [15:0] BROADCAST_ID = 16'hFFFF;
  localparam logic [15:0] INVALID_HOPS = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIELDS,
`ifdef PKT_CHECKSUM_EN
    S_CHK,
`endif
    S_EMIT,
    S_DROP
  } rx_state_e;

  // Word count including the header; zero for the invalid type.
  function automatic logic [3:0] pkt_len(input pkt_type_e t);
    case (t)
      PT_HEARTBEAT:   pkt_len = LEN_HEARTBEAT;
      PT_CH_ELECT:    pkt_len = LEN_CH_ELECT;
      PT_CH_TIMESLOT: pkt_len = LEN_CH_TIMESLOT;
      PT_INVALID:     pkt_len = 4'd0;
      default:        pkt_len = LEN_GENERIC;
    endcase
  endfunction

endpackage

// File: rtl/pkt_rx_parser_if.sv
// Radio word stream handshake between the receiver front end and the packet parser.
interface pkt_rx_parser_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  rx_last;
  logic [WORD_WIDTH-1:0] rx_data;

  modport master (output rx_valid, output rx_data, output rx_last, input rx_ready);
  modport slave  (input rx_valid, input rx_data, input rx_last, output rx_ready);
endinterface

// File: rtl/pkt_rx_parser.sv
// Packet field parser: decodes a word stream into registered packet fields.
// Optional trailing XOR checksum word when PKT_CHECKSUM_EN is defined.
module pkt_rx_parser
  import pkt_rx_parser_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned DROP_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  nrst,
  pkt_rx_parser_if.slave        rx,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  output logic [2:0]            fPacketType,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fDestinationID,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fChosenCH,
  output logic [WORD_WIDTH-1:0] fHopsFromCH,
  output logic [5:0]            fTimeslot,
  output logic                  pkt_valid,
  output logic                  iAmDestination,
  output logic                  pkt_err
);

  localparam int unsigned DT_W = $clog2(DROP_TIMEOUT + 1);
  localparam logic [WORD_WIDTH-1:0] BCAST   = WORD_WIDTH'(BROADCAST_ID);
  localparam logic [WORD_WIDTH-1:0] NO_HOPS = WORD_WIDTH'(INVALID_HOPS);

  typedef struct packed {
    logic [2:0]            ptype;
    logic [5:0]            ts;
    logic [WORD_WIDTH-1:0] src;
    logic [WORD_WIDTH-1:0] dst;
    logic [WORD_WIDTH-1:0] shops;
    logic [WORD_WIDTH-1:0] qval;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] ch;
    logic [WORD_WIDTH-1:0] hch;
    logic                  iam;
  } fields_t;

  localparam fields_t FIELDS_RST = '{
    ptype: 3'b111, ts: '0, src: '0, dst: '0, shops: NO_HOPS,
    qval: '0, energy: '0, ch: '0, hch: NO_HOPS, iam: 1'b0
  };

  rx_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DT_W-1:0]       drop_cnt_q, drop_cnt_d;
  pkt_type_e             hdr_type_q, hdr_type_d;
  logic [5:0]            hdr_ts_q, hdr_ts_d;
  logic [WORD_WIDTH-1:0] slot_q [1:7];
  logic [WORD_WIDTH-1:0] slot_d [1:7];
  fields_t               out_q, out_d;
  logic                  pkt_valid_q, pkt_valid_d;
  logic                  pkt_err_q, pkt_err_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  accept;
  logic                  load;
  logic [3:0]            len;
`ifdef PKT_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic [WORD_WIDTH-1:0] chk_q, chk_d;
`endif

  assign accept = rx.rx_valid && rx_ready_q;
  assign len    = pkt_len(hdr_type_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drop_cnt_d  = drop_cnt_q;
    hdr_type_d  = hdr_type_q;
    hdr_ts_d    = hdr_ts_q;
    slot_d      = slot_q;
    out_d       = out_q;
    pkt_valid_d = 1'b0;
    pkt_err_d   = 1'b0;
    load        = 1'b0;
`ifdef PKT_CHECKSUM_EN
    acc_d       = acc_q;
    chk_d       = chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hdr_type_d = pkt_type_e'(rx.rx_data[15:13]);
          hdr_ts_d   = rx.rx_data[5:0];
          // Preload absent-field defaults so short packet types need no masking at emit.
          for (int unsigned i = 1; i <= 7; i++) begin
            slot_d[i] = (i == 3 || i == 7) ? NO_HOPS : '0;
          end
`ifdef PKT_CHECKSUM_EN
          acc_d = rx.rx_data;
`endif
          if (rx.rx_last) begin
            pkt_err_d = 1'b1;
          end else if (hdr_type_d == PT_INVALID) begin
            state_d = S_DROP;
          end else begin
            state_d = S_FIELDS;
            cnt_d   = 4'd1;
          end
        end
      end

      S_FIELDS: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
`ifdef PKT_CHECKSUM_EN
          if (cnt_q == len) begin
            chk_d   = rx.rx_data;
            state_d = rx.rx_last ? S_CHK : S_DROP;
          end else begin
            slot_d[cnt_q[2:0]] = rx.rx_data;
            acc_d              = acc_q ^ rx.rx_data;
            if (rx.rx_last) begin
              state_d   = S_IDLE;
              pkt_err_d = 1'b1;
            end
          end
`else
          slot_d[cnt_q[2:0]] = rx.rx_data;
          if (cnt_q == len - 4'd1) begin
            if (rx.rx_last) begin
              state_d = S_EMIT;
              load    = 1'b1;
            end else begin
              state_d = S_DROP;
            end
          end else if (rx.rx_last) begin
            state_d   = S_IDLE;
            pkt_err_d = 1'b1;
          end
`endif
        end
      end

`ifdef PKT_CHECKSUM_EN
      S_CHK: begin
        if (acc_q == chk_q) begin
          state_d = S_EMIT;
          load    = 1'b1;
        end else begin
          state_d   = S_IDLE;
          pkt_err_d = 1'b1;
        end
      end
`endif

      S_EMIT: state_d = S_IDLE;

      S_DROP: begin
        if ((accept && rx.rx_last) || drop_cnt_q == DT_W'(DROP_TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          pkt_err_d = 1'b1;
        end else begin
          drop_cnt_d = drop_cnt_q + DT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != S_FIELDS) cnt_d = '0;
    if (state_d != S_DROP) drop_cnt_d = '0;

    // Outputs and pkt_valid load on entry to EMIT so the pulse is visible in the EMIT cycle.
    if (load) begin
      out_d.ptype  = hdr_type_q;
      out_d.ts     = hdr_ts_q;
      out_d.src    = slot_d[1];
      out_d.dst    = slot_d[2];
      out_d.shops  = slot_d[3];
      out_d.qval   = slot_d[4];
      out_d.energy = slot_d[5];
      out_d.ch     = slot_d[6];
      out_d.hch    = slot_d[7];
      out_d.iam    = (slot_d[2] == myNodeID) || (slot_d[2] == BCAST);
      pkt_valid_d  = 1'b1;
    end

`ifdef PKT_CHECKSUM_EN
    rx_ready_d = (state_d != S_EMIT) && (state_d != S_CHK);
`else
    rx_ready_d = (state_d != S_EMIT);
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drop_cnt_q  <= '0;
      hdr_type_q  <= PT_INVALID;
      hdr_ts_q    <= '0;
      slot_q      <= '{default: '0};
      out_q       <= FIELDS_RST;
      pkt_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
      rx_ready_q  <= 1'b1;
`ifdef PKT_CHECKSUM_EN
      acc_q       <= '0;
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      hdr_type_q  <= hdr_type_d;
      hdr_ts_q    <= hdr_ts_d;
      slot_q      <= slot_d;
      out_q       <= out_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_err_q   <= pkt_err_d;
      rx_ready_q  <= rx_ready_d;
`ifdef PKT_CHECKSUM_EN
      acc_q       <= acc_d;
      chk_q       <= chk_d;
`endif
    end
  end

  assign rx.rx_ready     = rx_ready_q;
  assign fPacketType     = out_q.ptype;
  assign fTimeslot       = out_q.ts;
  assign fSourceID       = out_q.src;
  assign fDestinationID  = out_q.dst;
  assign fSourceHops     = out_q.shops;
  assign fQValue         = out_q.qval;
  assign fEnergyLeft     = out_q.energy;
  assign fChosenCH       = out_q.ch;
  assign fHopsFromCH     = out_q.hch;
  assign iAmDestination  = out_q.iam;
  assign pkt_valid       = pkt_valid_q;
  assign pkt_err         = pkt_err_q;

endmodule

// File: tb/tb_pkt_rx_parser.sv
// Directed self-checking bench for pkt_rx_parser (default and PKT_CHECKSUM_EN builds).
module tb_pkt_rx_parser;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] my_id = 16'h000C;
  logic [2:0]  fPacketType;
  logic [15:0] fSourceID, fDestinationID, fSourceHops, fQValue;
  logic [15:0] fEnergyLeft, fChosenCH, fHopsFromCH;
  logic [5:0]  fTimeslot;
  logic        pkt_valid, iAmDestination, pkt_err;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int err_seen = 0;
  logic [15:0] pk [$];

`ifdef PKT_CHECKSUM_EN
  localparam int TO_WORDS = 71;
`else
  localparam int TO_WORDS = 70;
`endif

  pkt_rx_parser_if #(.WORD_WIDTH(16)) rx_if ();

  pkt_rx_parser #(.WORD_WIDTH(16), .DROP_TIMEOUT(64)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .rx             (rx_if.slave),
    .myNodeID       (my_id),
    .fPacketType    (fPacketType),
    .fSourceID      (fSourceID),
    .fDestinationID (fDestinationID),
    .fSourceHops    (fSourceHops),
    .fQValue        (fQValue),
    .fEnergyLeft    (fEnergyLeft),
    .fChosenCH      (fChosenCH),
    .fHopsFromCH    (fHopsFromCH),
    .fTimeslot      (fTimeslot),
    .pkt_valid      (pkt_valid),
    .iAmDestination (iAmDestination),
    .pkt_err        (pkt_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_valid === 1'b1) valid_seen++;
    if (pkt_err === 1'b1) err_seen++;
  end

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [15:0] d, input logic last);
    int unsigned n;
    n = 0;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = d;
    rx_if.rx_last  = last;
    while (rx_if.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_word_ready: rx_ready=%b after %0d cycles, required 1", rx_if.rx_ready, n);
    end
    @(posedge clk);
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    rx_if.rx_last  = 1'b0;
  endtask

  // Sends the global packet pk; returns in the cycle where pkt_valid is expected.
  task automatic send_pkt();
`ifdef PKT_CHECKSUM_EN
    logic [15:0] x;
    x = '0;
    for (int i = 0; i < pk.size(); i++) begin
      x ^= pk[i];
      send_word(pk[i], 1'b0);
    end
    send_word(x, 1'b1);
    @(negedge clk);
`else
    for (int i = 0; i < pk.size(); i++) send_word(pk[i], i == pk.size() - 1);
`endif
  endtask

  task automatic test_reset();
    rx_if.rx_valid = 1'b0; rx_if.rx_last = 1'b0; rx_if.rx_data = '0;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", pkt_valid); end
    checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", pkt_err); end
    checks++; if (fPacketType !== 3'b111) begin errors++; $display("FAIL rst_type: got %b required 111", fPacketType); end
    checks++; if (fSourceHops !== 16'hFFFF || fHopsFromCH !== 16'hFFFF) begin errors++; $display("FAIL rst_hops: got %h/%h required ffff/ffff", fSourceHops, fHopsFromCH); end
    checks++; if ({fSourceID, fDestinationID, fQValue, fEnergyLeft, fChosenCH, fTimeslot, iAmDestination} !== '0) begin errors++; $display("FAIL rst_zero: got %h %h %h %h %h %h %b required all 0", fSourceID, fDestinationID, fQValue, fEnergyLeft, fChosenCH, fTimeslot, iAmDestination); end
    checks++; if (rx_if.rx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", rx_if.rx_ready); end
  endtask

  task automatic test_heartbeat();
    int v0;
    v0 = valid_seen;
    pk = {16'h0000, 16'h0003, 16'h000C, 16'h0001, 16'h0000, 16'h7FFC};
    send_pkt();
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL hb_latency: pkt_valid=%b required 1", pkt_valid); end
    checks++; if (rx_if.rx_ready !== 1'b0) begin errors++; $display("FAIL hb_emit_ready: got %b required 0", rx_if.rx_ready); end
    checks++; if (fPacketType !== 3'b000 || fSourceID !== 16'h0003 || fDestinationID !== 16'h000C) begin errors++; $display("FAIL hb_ids: got %b %h %h required 000 0003 000c", fPacketType, fSourceID, fDestinationID); end
    checks++; if (fSourceHops !== 16'h0001 || fQValue !== 16'h0000 || fEnergyLeft !== 16'h7FFC) begin errors++; $display("FAIL hb_body: got %h %h %h required 0001 0000 7ffc", fSourceHops, fQValue, fEnergyLeft); end
    checks++; if (fChosenCH !== 16'h0000 || fHopsFromCH !== 16'hFFFF) begin errors++; $display("FAIL hb_absent: got %h %h required 0000 ffff", fChosenCH, fHopsFromCH); end
    checks++; if (iAmDestination !== 1'b1) begin errors++; $display("FAIL hb_iam: got %b required 1", iAmDestination); end
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b0 || fEnergyLeft !== 16'h7FFC) begin errors++; $display("FAIL hb_pulse_hold: valid=%b energy=%h required 0 7ffc", pkt_valid, fEnergyLeft); end
    checks++; if (valid_seen - v0 !== 1) begin errors++; $display("FAIL hb_pulse_count: got %0d required 1", valid_seen - v0); end
  endtask

  task automatic test_ch_election();
    pk = {16'h2015, 16'h0007, 16'hFFFF, 16'h0002, 16'h1234, 16'h5678, 16'h0009, 16'h0003};
    send_pkt();
    checks++; if (pkt_valid !== 1'b1 || iAmDestination !== 1'b1) begin errors++; $display("FAIL che_valid_iam: got %b %b required 1 1", pkt_valid, iAmDestination); end
    checks++; if (fPacketType !== 3'b001 || fTimeslot !== 6'h15 || fSourceID !== 16'h0007) begin errors++; $display("FAIL che_hdr: got %b %h %h required 001 15 0007", fPacketType, fTimeslot, fSourceID); end
    checks++; if (fSourceHops !== 16'h0002 || fQValue !== 16'h1234 || fEnergyLeft !== 16'h5678) begin errors++; $display("FAIL che_body: got %h %h %h required 0002 1234 5678", fSourceHops, fQValue, fEnergyLeft); end
    checks++; if (fChosenCH !== 16'h0009 || fHopsFromCH !== 16'h0003) begin errors++; $display("FAIL che_ch: got %h %h required 0009 0003", fChosenCH, fHopsFromCH); end
    @(negedge clk);
  endtask

  task automatic test_ch_timeslot();
    pk = {16'h403F, 16'h0005, 16'h0021};
    send_pkt();
    checks++; if (pkt_valid !== 1'b1 || iAmDestination !== 1'b0) begin errors++; $display("FAIL cts_valid_iam: got %b %b required 1 0", pkt_valid, iAmDestination); end
    checks++; if (fPacketType !== 3'b010 || fTimeslot !== 6'h3F || fSourceID !== 16'h0005 || fDestinationID !== 16'h0021) begin errors++; $display("FAIL cts_hdr: got %b %h %h %h required 010 3f 0005 0021", fPacketType, fTimeslot, fSourceID, fDestinationID); end
    checks++; if (fSourceHops !== 16'hFFFF || fQValue !== 16'h0 || fEnergyLeft !== 16'h0 || fChosenCH !== 16'h0 || fHopsFromCH !== 16'hFFFF) begin errors++; $display("FAIL cts_absent: got %h %h %h %h %h required ffff 0 0 0 ffff", fSourceHops, fQValue, fEnergyLeft, fChosenCH, fHopsFromCH); end
    @(negedge clk);
  endtask

  task automatic test_invalid_type();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_word(16'hE000, 1'b0);
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b0);
    send_word(16'h4444, 1'b1);
    checks++; if (pkt_err !== 1'b1) begin errors++; $display("FAIL inv_err: got %b required 1", pkt_err); end
    send_word(16'hE001, 1'b1);
    checks++; if (pkt_err !== 1'b1) begin errors++; $display("FAIL inv_hdr_last_err: got %b required 1", pkt_err); end
    @(negedge clk);
    checks++; if (err_seen - e0 !== 2 || valid_seen - v0 !== 0) begin errors++; $display("FAIL inv_pulses: err=%0d valid=%0d required 2 0", err_seen - e0, valid_seen - v0); end
    checks++; if (fPacketType !== 3'b010 || fSourceID !== 16'h0005 || fHopsFromCH !== 16'hFFFF) begin errors++; $display("FAIL inv_hold: got %b %h %h required 010 0005 ffff", fPacketType, fSourceID, fHopsFromCH); end
  endtask

  task automatic test_early_last();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_word(16'h0000, 1'b0);
    send_word(16'h0003, 1'b0);
    send_word(16'h000C, 1'b1);
    checks++; if (pkt_err !== 1'b1 || rx_if.rx_ready !== 1'b1) begin errors++; $display("FAIL early_err: err=%b ready=%b required 1 1", pkt_err, rx_if.rx_ready); end
    pk = {16'h0005, 16'h0009, 16'h0001, 16'h0004, 16'h0002, 16'h0100};
    send_pkt();
    checks++; if (pkt_valid !== 1'b1 || fSourceID !== 16'h0009 || fEnergyLeft !== 16'h0100 || fTimeslot !== 6'h05 || iAmDestination !== 1'b0) begin errors++; $display("FAIL early_next: got %b %h %h %h %b required 1 0009 0100 05 0", pkt_valid, fSourceID, fEnergyLeft, fTimeslot, iAmDestination); end
    @(negedge clk);
    checks++; if (err_seen - e0 !== 1 || valid_seen - v0 !== 1) begin errors++; $display("FAIL early_pulses: err=%0d valid=%0d required 1 1", err_seen - e0, valid_seen - v0); end
  endtask

  task automatic test_drop_last();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    for (int i = 0; i < 7; i++) send_word(16'(i * 3), 1'b0);
    checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL drop_early_err: got %b required 0", pkt_err); end
    send_word(16'h00AA, 1'b1);
    checks++; if (pkt_err !== 1'b1) begin errors++; $display("FAIL drop_last_err: got %b required 1", pkt_err); end
    @(negedge clk);
    checks++; if (err_seen - e0 !== 1 || valid_seen - v0 !== 0 || fSourceID !== 16'h0009) begin errors++; $display("FAIL drop_pulses: err=%0d valid=%0d src=%h required 1 0 0009", err_seen - e0, valid_seen - v0, fSourceID); end
  endtask

  task automatic test_timeout();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    for (int i = 0; i < TO_WORDS - 1; i++) send_word(16'(i), 1'b0);
    checks++; if (err_seen - e0 !== 0) begin errors++; $display("FAIL to_premature: err pulses=%0d required 0", err_seen - e0); end
    send_word(16'h0BAD, 1'b0);
    checks++; if (pkt_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b required 1", pkt_err); end
    @(negedge clk);
    checks++; if (err_seen - e0 !== 1 || valid_seen - v0 !== 0 || rx_if.rx_ready !== 1'b1) begin errors++; $display("FAIL to_pulses: err=%0d valid=%0d ready=%b required 1 0 1", err_seen - e0, valid_seen - v0, rx_if.rx_ready); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_seen;
    pk = {16'h0011, 16'h0021, 16'hFFFF, 16'h0002, 16'h0033, 16'h0044};
    send_pkt();
    checks++; if (pkt_valid !== 1'b1 || fSourceID !== 16'h0021 || iAmDestination !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b %h %b required 1 0021 1", pkt_valid, fSourceID, iAmDestination); end
    pk = {16'h0012, 16'h0022, 16'h0099, 16'h0003, 16'h0055, 16'h0066};
    send_pkt();
    checks++; if (pkt_valid !== 1'b1 || fSourceID !== 16'h0022 || fEnergyLeft !== 16'h0066 || iAmDestination !== 1'b0) begin errors++; $display("FAIL b2b_second: got %b %h %h %b required 1 0022 0066 0", pkt_valid, fSourceID, fEnergyLeft, iAmDestination); end
    @(negedge clk);
    checks++; if (valid_seen - v0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d required 2", valid_seen - v0); end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    send_word(16'h2003, 1'b0);
    send_word(16'h0007, 1'b0);
    send_word(16'h000C, 1'b0);
    nrst = 1'b0;
    @(negedge clk);
    checks++; if (fPacketType !== 3'b111 || fSourceID !== 16'h0 || fSourceHops !== 16'hFFFF || fHopsFromCH !== 16'hFFFF || iAmDestination !== 1'b0) begin errors++; $display("FAIL rmid_values: got %b %h %h %h %b required 111 0000 ffff ffff 0", fPacketType, fSourceID, fSourceHops, fHopsFromCH, iAmDestination); end
    v0 = valid_seen; e0 = err_seen;
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (valid_seen - v0 !== 0 || err_seen - e0 !== 0) begin errors++; $display("FAIL rmid_pulses: valid=%0d err=%0d required 0 0", valid_seen - v0, err_seen - e0); end
    pk = {16'h0000, 16'h0003, 16'h000C, 16'h0001, 16'h0000, 16'h7FFC};
    send_pkt();
    checks++; if (pkt_valid !== 1'b1 || fSourceID !== 16'h0003 || fEnergyLeft !== 16'h7FFC) begin errors++; $display("FAIL rmid_recover: got %b %h %h required 1 0003 7ffc", pkt_valid, fSourceID, fEnergyLeft); end
    @(negedge clk);
  endtask

`ifdef PKT_CHECKSUM_EN
  task automatic test_checksum_bad();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_word(16'h4001, 1'b0);
    send_word(16'h0005, 1'b0);
    send_word(16'h0006, 1'b0);
    send_word(16'h4001 ^ 16'h0005 ^ 16'h0006 ^ 16'h0010, 1'b1);
    @(negedge clk);
    checks++; if (pkt_err !== 1'b1 || pkt_valid !== 1'b0) begin errors++; $display("FAIL chk_bad: err=%b valid=%b required 1 0", pkt_err, pkt_valid); end
    @(negedge clk);
    checks++; if (err_seen - e0 !== 1 || valid_seen - v0 !== 0 || fSourceID !== 16'h0003) begin errors++; $display("FAIL chk_bad_pulses: err=%0d valid=%0d src=%h required 1 0 0003", err_seen - e0, valid_seen - v0, fSourceID); end
  endtask
`endif

  initial begin
    rx_if.rx_valid = 1'b0;
    rx_if.rx_last  = 1'b0;
    rx_if.rx_data  = '0;
    @(negedge clk);
    test_reset();
    test_heartbeat();
    test_ch_election();
    test_ch_timeslot();
    test_invalid_type();
    test_early_last();
    test_drop_last();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef PKT_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
